// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI PHY responder: TX CMD opcodes, FSM states,
// register map layout and RX CMD byte packing.
package ulpi_pkg;

  typedef enum logic [1:0] {
    CMD_NOOP     = 2'b00,
    CMD_TRANSMIT = 2'b01,
    CMD_REGW     = 2'b10,
    CMD_REGR     = 2'b11
  } ulpi_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_ACK, ST_W_DATA, ST_W_STP,
    ST_R_ACK, ST_R_T1, ST_R_DATA, ST_R_T2,
    ST_T_ACK, ST_T_DATA,
    ST_RX_T1, ST_RX_CMD, ST_RX_T2
  } ulpi_state_e;

  localparam logic [5:0] ADDR_VID_LO = 6'h00;
  localparam logic [5:0] ADDR_VID_HI = 6'h01;
  localparam logic [5:0] ADDR_PID_LO = 6'h02;
  localparam logic [5:0] ADDR_PID_HI = 6'h03;

  // Each writable register owns base (write), base+1 (set), base+2 (clear).
  localparam int NUM_GRP  = 6;
  localparam int GRP_FUNC = 0;
  localparam logic [NUM_GRP-1:0][5:0] GRP_BASE = {6'h16, 6'h10, 6'h0D, 6'h0A, 6'h07, 6'h04};
  localparam logic [NUM_GRP-1:0][7:0] GRP_DFLT = {8'h00, 8'h1F, 8'h1F, 8'h06, 8'h00, 8'h41};
  localparam logic [7:0] FC_RESET_MASK = 8'h20;

  localparam int RXCMD_LS_LSB = 0;
  localparam int RXCMD_LS_W   = 2;

  function automatic logic [7:0] rx_cmd_byte(input logic [1:0] ls);
    rx_cmd_byte = '0;
    rx_cmd_byte[RXCMD_LS_LSB +: RXCMD_LS_W] = ls;
  endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// PHY register file: read-only ID bytes, set/clear register groups and the
// self-clearing Function Control reset bit. One write port, one comb read port.
module ulpi_phy_regfile
  import ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0006
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata,
  output logic [7:0] func_ctrl
);

  logic [NUM_GRP-1:0][7:0] regs;
  logic [NUM_GRP-1:0]      whit, rhit;
  logic [NUM_GRP-1:0][1:0] wsel;

  always_comb begin
    for (int g = 0; g < NUM_GRP; g++) begin
      whit[g] = (waddr >= GRP_BASE[g]) && (waddr <= GRP_BASE[g] + 6'd2);
      rhit[g] = (raddr >= GRP_BASE[g]) && (raddr <= GRP_BASE[g] + 6'd2);
      wsel[g] = 2'(waddr - GRP_BASE[g]);
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      regs <= GRP_DFLT;
    end else begin
      for (int g = 0; g < NUM_GRP; g++) begin
        if (we && whit[g]) begin
          case (wsel[g])
            2'd0:    regs[g] <= wdata;
            2'd1:    regs[g] <= regs[g] | wdata;
            default: regs[g] <= regs[g] & ~wdata;
          endcase
        end else if (g == GRP_FUNC) begin
          // PHY reset bit acts as a pulse: drop it on the cycle after it lands.
          regs[g] <= regs[g] & ~FC_RESET_MASK;
        end
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int g = 0; g < NUM_GRP; g++)
      if (rhit[g]) rdata = regs[g];
    case (raddr)
      ADDR_VID_LO: rdata = VENDOR_ID[7:0];
      ADDR_VID_HI: rdata = VENDOR_ID[15:8];
      ADDR_PID_LO: rdata = PRODUCT_ID[7:0];
      ADDR_PID_HI: rdata = PRODUCT_ID[15:8];
      default: ;
    endcase
  end

  assign func_ctrl = regs[GRP_FUNC];

endmodule

// File: rtl/ulpi_phy_responder.sv
// PHY side of the ULPI bus: decodes link TX CMDs, serves register access,
// sinks transmit payloads and reports line state changes as RX CMDs.
module ulpi_phy_responder
  import ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0006
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic [7:0] ULPI_DATA_IN,
  output logic [7:0] ULPI_DATA_OUT,
  output logic       ULPI_DATA_OE,
  output logic       DIR,
  output logic       NXT,
  input  logic       STP,
  input  logic [1:0] LINESTATE,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  output logic       TX_LAST,
  output logic [7:0] FUNC_CTRL
);

  ulpi_state_e state, state_n;
  logic [5:0]  addr;
  logic [7:0]  wdata, rdata;
  logic [1:0]  last_ls;
  logic        we;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        // PHY owns the bus first: a line change beats any link command.
        if (LINESTATE != last_ls) state_n = ST_RX_T1;
        else begin
          case (ulpi_cmd_e'(ULPI_DATA_IN[7:6]))
            CMD_TRANSMIT: state_n = ST_T_ACK;
            CMD_REGW:     state_n = ST_W_ACK;
            CMD_REGR:     state_n = ST_R_ACK;
            default:      state_n = ST_IDLE;
          endcase
        end
      end
      ST_W_ACK:  state_n = STP ? ST_IDLE : ST_W_DATA;
      ST_W_DATA: state_n = ST_W_STP;
      ST_W_STP:  state_n = STP ? ST_IDLE : ST_W_STP;
      ST_R_ACK:  state_n = STP ? ST_IDLE : ST_R_T1;
      ST_R_T1:   state_n = ST_R_DATA;
      ST_R_DATA: state_n = ST_R_T2;
      ST_T_ACK:  state_n = STP ? ST_IDLE : ST_T_DATA;
      ST_T_DATA: state_n = STP ? ST_IDLE : ST_T_DATA;
      ST_RX_T1:  state_n = ST_RX_CMD;
      ST_RX_CMD: state_n = ST_RX_T2;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign we = (state == ST_W_STP) && STP && !rst;

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state         <= ST_IDLE;
      DIR           <= 1'b0;
      NXT           <= 1'b0;
      ULPI_DATA_OE  <= 1'b0;
      ULPI_DATA_OUT <= 8'h00;
      TX_DATA       <= 8'h00;
      TX_VALID      <= 1'b0;
      TX_LAST       <= 1'b0;
      last_ls       <= LINESTATE;
      addr          <= 6'h00;
      wdata         <= 8'h00;
    end else begin
      state        <= state_n;
      NXT          <= state_n inside {ST_W_ACK, ST_W_DATA, ST_R_ACK, ST_T_ACK, ST_T_DATA};
      DIR          <= state_n inside {ST_R_T1, ST_R_DATA, ST_R_T2, ST_RX_T1, ST_RX_CMD, ST_RX_T2};
      ULPI_DATA_OE <= state_n inside {ST_R_DATA, ST_RX_CMD};
      if (state_n == ST_R_DATA)       ULPI_DATA_OUT <= rdata;
      else if (state_n == ST_RX_CMD)  ULPI_DATA_OUT <= rx_cmd_byte(LINESTATE);
      else                            ULPI_DATA_OUT <= 8'h00;
      if (state_n == ST_RX_CMD) last_ls <= LINESTATE;
      if (state == ST_IDLE && state_n inside {ST_W_ACK, ST_R_ACK, ST_T_ACK})
        addr <= ULPI_DATA_IN[5:0];
      if (state == ST_W_DATA) wdata <= ULPI_DATA_IN;
      TX_VALID <= (state == ST_T_DATA) && !STP;
      if ((state == ST_T_DATA) && !STP) TX_DATA <= ULPI_DATA_IN;
      TX_LAST  <= (state inside {ST_T_ACK, ST_T_DATA}) && STP;
    end
  end

  ulpi_phy_regfile #(
    .VENDOR_ID (VENDOR_ID),
    .PRODUCT_ID(PRODUCT_ID)
  ) u_regfile (
    .clk_ext  (clk_ext),
    .rst      (rst),
    .we       (we),
    .waddr    (addr),
    .wdata    (wdata),
    .raddr    (addr),
    .rdata    (rdata),
    .func_ctrl(FUNC_CTRL)
  );

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Directed bench for the ULPI PHY responder: register writes/reads, set/clear,
// IDs, transmit sink, RX CMD collision, early STP and mid-read reset.
module tb_ulpi_phy_responder;

  logic       clk_ext = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       stp = 1'b0;
  logic [1:0] ls = 2'b00;
  logic [7:0] dout, tx_data, func_ctrl;
  logic       oe, dir, nxt, tx_valid, tx_last;
  int checks = 0;
  int errors = 0;

  ulpi_phy_responder dut (
    .clk_ext      (clk_ext),
    .rst          (rst),
    .ULPI_DATA_IN (data_in),
    .ULPI_DATA_OUT(dout),
    .ULPI_DATA_OE (oe),
    .DIR          (dir),
    .NXT          (nxt),
    .STP          (stp),
    .LINESTATE    (ls),
    .TX_DATA      (tx_data),
    .TX_VALID     (tx_valid),
    .TX_LAST      (tx_last),
    .FUNC_CTRL    (func_ctrl)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ext);
    #1;
  endtask

  // Link-side register write: cmd, hold cmd during ack, data, then STP.
  task automatic regw(input logic [5:0] a, input logic [7:0] d);
    data_in = {2'b10, a};
    step(); chk("w_ack_nxt", nxt, 1);
    step(); chk("w_data_nxt", nxt, 1); data_in = d;
    step(); chk("w_stp_nxt", nxt, 0); data_in = 8'h00; stp = 1'b1;
    step(); stp = 1'b0;
  endtask

  task automatic regr(input string tag, input logic [5:0] a, input logic [7:0] exp);
    data_in = {2'b11, a};
    step(); chk({tag, "_ack_nxt"}, nxt, 1); chk({tag, "_ack_dir"}, dir, 0); data_in = 8'h00;
    step(); chk({tag, "_t1_dir"}, dir, 1); chk({tag, "_t1_oe"}, oe, 0);
    step(); chk({tag, "_dir"}, dir, 1); chk({tag, "_oe"}, oe, 1); chk({tag, "_data"}, dout, exp);
    step(); chk({tag, "_t2_dir"}, dir, 1); chk({tag, "_t2_oe"}, oe, 0);
    step(); chk({tag, "_idle_dir"}, dir, 0);
  endtask

  initial begin
    step(); step();
    chk("rst_dir", dir, 0); chk("rst_nxt", nxt, 0); chk("rst_oe", oe, 0);
    chk("rst_dout", dout, 8'h00); chk("rst_txv", tx_valid, 0); chk("rst_txl", tx_last, 0);
    chk("rst_func", func_ctrl, 8'h41);
    rst = 1'b0;

    regw(6'h16, 8'h3A);
    regr("scratch", 6'h16, 8'h3A);

    regw(6'h08, 8'h0F);
    regw(6'h09, 8'h05);
    regr("ifctrl", 6'h07, 8'h0A);

    regr("vid_lo", 6'h00, 8'h24);
    regr("vid_hi", 6'h01, 8'h04);
    regr("pid_lo", 6'h02, 8'h06);
    regw(6'h00, 8'h55);
    regr("vid_ro", 6'h00, 8'h24);

    regw(6'h13, 8'hFF);
    regr("unmapped", 6'h13, 8'h00);
    regw(6'h0C, 8'h04);
    regr("otg_clr", 6'h0A, 8'h02);

    // Function Control reset bit pulses for one cycle then clears.
    regw(6'h05, 8'h20);
    chk("fc_rst_set", func_ctrl, 8'h61);
    step(); chk("fc_rst_clr", func_ctrl, 8'h41);

    // Transmit 3 bytes.
    data_in = 8'h40;
    step(); chk("t_ack_nxt", nxt, 1);
    step(); chk("t_nxt", nxt, 1); chk("t_v0", tx_valid, 0); data_in = 8'hC3;
    step(); chk("t_v1", tx_valid, 1); chk("t_d1", tx_data, 8'hC3); data_in = 8'h11;
    step(); chk("t_v2", tx_valid, 1); chk("t_d2", tx_data, 8'h11); data_in = 8'h22;
    step(); chk("t_v3", tx_valid, 1); chk("t_d3", tx_data, 8'h22); chk("t_l3", tx_last, 0);
    data_in = 8'h00; stp = 1'b1;
    step(); chk("t_v4", tx_valid, 0); chk("t_last", tx_last, 1); stp = 1'b0;
    step(); chk("t_last_end", tx_last, 0); chk("t_v5", tx_valid, 0);

    // Line state change collides with a scratch write.
    ls = 2'b01; data_in = 8'h96;
    step(); chk("rx_t1_dir", dir, 1); chk("rx_t1_oe", oe, 0); chk("rx_t1_nxt", nxt, 0); data_in = 8'h00;
    step(); chk("rx_dir", dir, 1); chk("rx_oe", oe, 1); chk("rx_cmd", dout, 8'h01); chk("rx_nxt", nxt, 0);
    step(); chk("rx_t2_dir", dir, 1); chk("rx_t2_oe", oe, 0);
    step(); chk("rx_idle_dir", dir, 0); chk("rx_idle_nxt", nxt, 0);
    regr("scratch_keep", 6'h16, 8'h3A);

    // STP during write ack aborts the write.
    data_in = 8'h96;
    step(); chk("es_ack_nxt", nxt, 1); data_in = 8'h00; stp = 1'b1;
    step(); chk("es_nxt", nxt, 0); stp = 1'b0;
    step(); chk("es_idle_nxt", nxt, 0);
    regr("scratch_es", 6'h16, 8'h3A);

    // Reset during read turnaround.
    data_in = 8'hC4;
    step(); data_in = 8'h00;
    step(); chk("rr_t1_dir", dir, 1);
    rst = 1'b1;
    step(); chk("rr_dir", dir, 0); chk("rr_oe", oe, 0); chk("rr_nxt", nxt, 0);
    rst = 1'b0;
    regr("func_dflt", 6'h04, 8'h41);
    chk("func_out", func_ctrl, 8'h41);
    regr("scratch_dflt", 6'h16, 8'h00);
    regr("fall_dflt", 6'h10, 8'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
